// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder sequencer with valid/ready on both sides; define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, r;
  logic [CW-1:0] cnt;
  logic c, s, cn;
  assign s = sa[0] ^ sb[0] ^ c;
  assign cn = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  assign in_ready = state == IDLE;
  assign busy = state == RUN;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      r <= '0;
      cnt <= '0;
      c <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa <= a;
          sb <= b;
          c <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          r <= {s, r[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          c <= cn;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum <= {s, r[WIDTH-1:1]};
            cout <= cn;
`ifdef SERIAL_ADD_OVF_EN
            ovf <= c ^ cn;
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic in_ready, out_valid, cout, busy;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
`endif
  int total = 0, pass_cnt = 0;
  logic [8:0] q[$];
  logic [8:0] exp_r;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    in_valid = 1;
    q.push_back({1'b0, x} + {1'b0, y});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_flags got rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid); else pass_cnt++;
    total++; if ({cout, sum} !== 9'h000) $display("FAIL reset_result got %h want 000", {cout, sum}); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] xa[4] = '{8'h00, 8'hFF, 8'h7F, 8'hFF};
    logic [7:0] xb[4] = '{8'h00, 8'h01, 8'h01, 8'hFF};
    int n;
    for (int i = 0; i < 4; i++) begin
      total++; if (in_ready !== 1'b1) $display("FAIL basic_ready[%0d] got %b want 1", i, in_ready); else pass_cnt++;
      send(xa[i], xb[i]);
      wait_out(n);
      total++; if (n !== 8) $display("FAIL basic_latency[%0d] got %0d want 8", i, n); else pass_cnt++;
      exp_r = q.pop_front();
      total++; if ({cout, sum} !== exp_r) $display("FAIL basic_sum[%0d] got %h want %h", i, {cout, sum}, exp_r); else pass_cnt++;
`ifdef SERIAL_ADD_OVF_EN
      total++; if (ovf !== ((xa[i][7] == xb[i][7]) && (exp_r[7] != xa[i][7]))) $display("FAIL basic_ovf[%0d] got %b", i, ovf); else pass_cnt++;
`endif
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_return[%0d] got rdy=%b ov=%b want 1 0", i, in_ready, out_valid); else pass_cnt++;
      total++; if ({cout, sum} !== exp_r) $display("FAIL basic_retain[%0d] got %h want %h", i, {cout, sum}, exp_r); else pass_cnt++;
    end
  endtask

  task automatic test_ignore;
    int cnt = 0;
    send(8'hA5, 8'h5A);
    a = 8'h11;
    b = 8'h22;
    in_valid = 1;
    for (int i = 0; i < 40; i++) begin
      if (busy && !in_ready) cnt++;
      if (out_valid) break;
      @(posedge clk); #1;
    end
    in_valid = 0;
    total++; if (cnt !== 8) $display("FAIL ignore_busy_cycles got %0d want 8", cnt); else pass_cnt++;
    exp_r = q.pop_front();
    total++; if (out_valid !== 1'b1 || {cout, sum} !== exp_r) $display("FAIL ignore_sum got ov=%b %h want 1 %h", out_valid, {cout, sum}, exp_r); else pass_cnt++;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_backpressure;
    int n;
    send(8'h12, 8'h34);
    wait_out(n);
    total++; if (n !== 8) $display("FAIL bp_latency got %0d want 8", n); else pass_cnt++;
    exp_r = q.pop_front();
    a = 8'h01;
    b = 8'h01;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp_r) $display("FAIL bp_hold[%0d] got ov=%b rdy=%b busy=%b %h want 1 0 0 %h", i, out_valid, in_ready, busy, {cout, sum}, exp_r); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1;
    q.push_back(9'h002);
    @(posedge clk); #1;
    out_ready = 0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release got rdy=%b busy=%b want 1 0", in_ready, busy); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 0;
    total++; if (busy !== 1'b1) $display("FAIL bp_accept got busy=%b want 1", busy); else pass_cnt++;
    wait_out(n);
    exp_r = q.pop_front();
    total++; if (n !== 8 || {cout, sum} !== exp_r) $display("FAIL bp_second got n=%0d %h want 8 %h", n, {cout, sum}, exp_r); else pass_cnt++;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_async_reset;
    int seen = 0, n;
    send(8'hF0, 8'h0F);
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    total++; if ({cout, sum} !== 9'h000 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL arst_immediate got %h ov=%b busy=%b rdy=%b want 000 0 0 1", {cout, sum}, out_valid, busy, in_ready); else pass_cnt++;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL arst_abort got %0d active cycles want 0", seen); else pass_cnt++;
    send(8'hC8, 8'h64);
    wait_out(n);
    exp_r = q.pop_front();
    total++; if (n !== 8 || {cout, sum} !== exp_r || exp_r !== 9'h12C) $display("FAIL arst_after got n=%0d %h want 8 12c", n, {cout, sum}); else pass_cnt++;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1, got = 0;
    logic prev;
    out_ready = 1;
    a = 8'h03;
    b = 8'h04;
    in_valid = 1;
    q.push_back(9'h007);
    prev = busy;
    for (int e = 1; e <= 60 && got < 2; e++) begin
      @(posedge clk); #1;
      if (busy && !prev) begin
        if (first < 0) begin
          first = e;
          a = 8'h85;
          b = 8'h86;
          q.push_back(9'h10B);
        end else begin
          second = e;
          in_valid = 0;
        end
      end
      prev = busy;
      if (out_valid) begin
        exp_r = q.pop_front();
        got++;
        total++; if ({cout, sum} !== exp_r) $display("FAIL b2b_sum[%0d] got %h want %h", got, {cout, sum}, exp_r); else pass_cnt++;
      end
    end
    in_valid = 0;
    out_ready = 0;
    total++; if (got !== 2) $display("FAIL b2b_results got %0d want 2", got); else pass_cnt++;
    total++; if (second - first !== 10) $display("FAIL b2b_spacing got %0d want 10", second - first); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore;
    test_backpressure;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
